// File: rtl/accel_pkg.sv
// Shared accelerator types: buffer role codes and scheduler states.
// A buffer is idle, being word-loaded (m0) or feeding the PE bus (m1).
package accel_pkg;

  localparam logic [1:0] BUF_IDLE = 2'd0;
  localparam logic [1:0] BUF_M0   = 2'd1;
  localparam logic [1:0] BUF_M1   = 2'd2;

  typedef enum logic [2:0] {
    PP_IDLE,
    PP_FILL,
    PP_OVERLAP,
    PP_DRAIN,
    PP_FIN
  } pp_state_t;

  // Role of buffer `sel` given both engines' outstanding work.
  function automatic logic [1:0] buf_mode(
    input logic sel,
    input logic ld_pend,
    input logic ld_sel,
    input logic cp_pend,
    input logic cp_sel
  );
    if (ld_pend && (ld_sel == sel)) return BUF_M0;
    if (cp_pend && (cp_sel == sel)) return BUF_M1;
    return BUF_IDLE;
  endfunction

endpackage

// File: rtl/pingpong_sched_hs_track.sv
// Pending/done bookkeeping for one engine handshake.
// A done counts only after the go cycle while work is outstanding.
module hs_track (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic go_i,
  input  logic done_i,
  output logic pend_o,
  output logic acc_o,
  output logic bad_o
);

  logic pend_q;

  assign acc_o  = done_i & pend_q;
  assign bad_o  = done_i & ~pend_q;
  assign pend_o = go_i | pend_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      pend_q <= 1'b0;
    end else begin
      pend_q <= go_i | (pend_q & ~acc_o);
    end
  end

endmodule

// File: rtl/pingpong_sched.sv
// Double-buffer scheduler: loads one buffer while the other computes,
// swapping roles every tile.
module pingpong_sched
  import accel_pkg::*;
#(
  parameter int TILE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [TILE_W-1:0] n_tiles,
  output logic              ld_go,
  output logic              ld_sel,
  output logic [TILE_W-1:0] ld_tile,
  input  logic              ld_done,
  output logic              cp_go,
  output logic              cp_sel,
  output logic [TILE_W-1:0] cp_tile,
  input  logic              cp_done,
  output logic [1:0]        f_mode,
  output logic [1:0]        s_mode,
  output logic              busy,
  output logic              done,
  output logic              err
);

  pp_state_t         state_q;
  logic              cur_q;
  logic [TILE_W-1:0] cnt_q;
  logic [TILE_W-1:0] n_q;
  logic              ld_go_q, ld_sel_q;
  logic              cp_go_q, cp_sel_q;
  logic [TILE_W-1:0] ld_tile_q, cp_tile_q;
  logic              ld_got_q, cp_got_q;
  logic              busy_q, done_q, err_q;

  logic ld_pend, ld_acc, ld_bad;
  logic cp_pend, cp_acc, cp_bad;
  logic ld_all_d, cp_all_d;

  hs_track u_ld (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (abort),
    .go_i   (ld_go_q),
    .done_i (ld_done),
    .pend_o (ld_pend),
    .acc_o  (ld_acc),
    .bad_o  (ld_bad)
  );

  hs_track u_cp (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (abort),
    .go_i   (cp_go_q),
    .done_i (cp_done),
    .pend_o (cp_pend),
    .acc_o  (cp_acc),
    .bad_o  (cp_bad)
  );

  assign ld_all_d = ld_got_q | ld_acc;
  assign cp_all_d = cp_got_q | cp_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PP_IDLE;
      cur_q     <= 1'b0;
      cnt_q     <= '0;
      n_q       <= '0;
      ld_go_q   <= 1'b0;
      ld_sel_q  <= 1'b0;
      ld_tile_q <= '0;
      cp_go_q   <= 1'b0;
      cp_sel_q  <= 1'b0;
      cp_tile_q <= '0;
      ld_got_q  <= 1'b0;
      cp_got_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ld_go_q <= 1'b0;
      cp_go_q <= 1'b0;
      done_q  <= 1'b0;
      if (abort) begin
        state_q  <= PP_IDLE;
        busy_q   <= 1'b0;
        ld_got_q <= 1'b0;
        cp_got_q <= 1'b0;
      end else begin
        if (ld_bad || cp_bad) err_q <= 1'b1;
        unique case (state_q)
          PP_IDLE: begin
            if (start) begin
              err_q  <= 1'b0;
              n_q    <= n_tiles;
              busy_q <= 1'b1;
              cur_q  <= 1'b0;
              if (n_tiles == '0) begin
                state_q <= PP_FIN;
              end else begin
                state_q   <= PP_FILL;
                ld_go_q   <= 1'b1;
                ld_sel_q  <= 1'b0;
                ld_tile_q <= '0;
                cnt_q     <= TILE_W'(1);
              end
            end
          end
          PP_FILL: begin
            if (ld_acc) begin
              cp_go_q   <= 1'b1;
              cp_sel_q  <= cur_q;
              cp_tile_q <= '0;
              if (n_q == TILE_W'(1)) begin
                state_q <= PP_DRAIN;
              end else begin
                state_q   <= PP_OVERLAP;
                ld_go_q   <= 1'b1;
                ld_sel_q  <= ~cur_q;
                ld_tile_q <= cnt_q;
                cnt_q     <= cnt_q + TILE_W'(1);
              end
            end
          end
          PP_OVERLAP: begin
            if (ld_all_d && cp_all_d) begin
              // Freshly loaded buffer becomes the compute side.
              ld_got_q  <= 1'b0;
              cp_got_q  <= 1'b0;
              cur_q     <= ~cur_q;
              cp_go_q   <= 1'b1;
              cp_sel_q  <= ~cur_q;
              cp_tile_q <= cnt_q - TILE_W'(1);
              if (cnt_q == n_q) begin
                state_q <= PP_DRAIN;
              end else begin
                ld_go_q   <= 1'b1;
                ld_sel_q  <= cur_q;
                ld_tile_q <= cnt_q;
                cnt_q     <= cnt_q + TILE_W'(1);
              end
            end else begin
              ld_got_q <= ld_all_d;
              cp_got_q <= cp_all_d;
            end
          end
          PP_DRAIN: begin
            if (cp_acc) begin
              state_q <= PP_FIN;
              done_q  <= 1'b1;
            end
          end
          PP_FIN: begin
            // Empty layers arrive without done armed; pulse it here.
            if (done_q) begin
              state_q <= PP_IDLE;
              busy_q  <= 1'b0;
            end else begin
              done_q <= 1'b1;
            end
          end
          default: state_q <= PP_IDLE;
        endcase
      end
    end
  end

  assign ld_go   = ld_go_q;
  assign ld_sel  = ld_sel_q;
  assign ld_tile = ld_tile_q;
  assign cp_go   = cp_go_q;
  assign cp_sel  = cp_sel_q;
  assign cp_tile = cp_tile_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign f_mode  = buf_mode(1'b0, ld_pend, ld_sel_q, cp_pend, cp_sel_q);
  assign s_mode  = buf_mode(1'b1, ld_pend, ld_sel_q, cp_pend, cp_sel_q);

endmodule
